timer_nch_apb: RTL and testbench
================================

Name: timer_nch_apb

Overview:
- Parametrised N-channel down-counting timer bank on APB; successor to the fixed two-timer block.
- Adds per-channel one-shot/periodic mode and interrupt mask, W1C interrupt status, and configurable counter width.
- Adds ETB on/off trigger vectors for any channel count and per-channel ETB trigger pulse outputs.
- Sits on the peripheral APB bus next to the other timer instances; intr feeds the interrupt controller, trig_out feeds the ETB.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_W, 32, counter/load width in bits (8..32)
ADDR_W, 8, APB address bits decoded (paddr[ADDR_W-1:0])

Ports:
pclk  in  1  single clock for APB and all counters
presetn  in  1  synchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  ADDR_W  byte address; bits [1:0] ignored
pwdata  in  32  write data
prdata  out  32  read data
etb_trig_en_on  in  NUM_CH  per-channel one-cycle pulse: set enable
etb_trig_en_off  in  NUM_CH  per-channel one-cycle pulse: clear enable
trig_out  out  NUM_CH  per-channel one-cycle pulse on expiry
intr  out  NUM_CH  per-channel level interrupt, raw & ~mask

Behaviour:
- Reset is synchronous: on a pclk edge with presetn=0, all registers clear. prdata=0, trig_out=0, intr=0, LOAD=0, VALUE=0, CTRL=0, RAW=0.
- Channel c register block sits at c*0x10:
  - +0x0 LOAD (RW, CNT_W bits, upper bits read 0).
  - +0x4 VALUE (RO).
  - +0x8 CTRL (RW): bit0 EN, bit1 MODE (1=periodic, 0=one-shot), bit2 MASK.
  - +0xC STAT (read: bit0 RAW; write 1 to bit0 clears RAW).
- Global registers: 0xA0 INTSTAT (RO, bit c = intr[c]); 0xA4 RAWSTAT (RO, bit c = RAW[c]).
- Unmapped addresses, and channels >= NUM_CH, read 0 and ignore writes.
- APB timing:
  - Zero wait states.
  - Write commits on the edge where psel&penable&pwrite=1.
  - prdata is combinational when psel&!pwrite; otherwise 0.
- Enable control:
  - EN is set by an APB write or by an etb_trig_en_on[c] pulse.
  - EN is cleared by an APB write, by etb_trig_en_off[c], or by a one-shot expiry.
  - Priority, highest first: expiry clear > etb off > etb on > APB write.
- Counting:
  - On an EN 0->1 transition, VALUE<=LOAD at that edge.
  - While EN=1 and VALUE!=0: VALUE decrements by 1 per cycle.
  - While EN=0: VALUE holds.
- Expiry, in a cycle where EN=1 and VALUE==0:
  - Next edge: RAW<=1 and trig_out[c]<=1 for exactly one cycle.
  - Periodic: VALUE<=LOAD and EN stays 1.
  - One-shot: EN<=0 and VALUE stays 0.
  - Period is LOAD+1 cycles. LOAD=0 in periodic mode expires every cycle, so trig_out stays high continuously.
- Enable held across expiry: a write of EN=1 while EN is already 1 does not reload.
- LOAD writes while running take effect at the next reload only.
- Simultaneous RAW set by expiry and W1C in the same cycle: set wins, RAW stays 1.
- intr[c] = RAW[c] & ~MASK[c]. It is combinational from registers, so intr rises one cycle after the expiry cycle, coincident with trig_out.
- Wrap-around: none. The counter never underflows below 0.
- Reset mid-count: next edge forces all state to 0 and suppresses any pending trig_out.

Test Plan:
- Periodic period: LOAD=3, CTRL=0x3 → VALUE sequence 3,2,1,0,3,2,…; trig_out pulses every 4 cycles; RAW=1; intr=1; W1C STAT=1 → intr=0.
- One-shot: LOAD=5, CTRL=0x1 → single trig_out 6 cycles after enable edge; CTRL reads 0x0; VALUE holds 0; no further pulses.
- Mask and collision: MASK=1 → RAWSTAT bit set, INTSTAT=0, intr=0. W1C issued in the same cycle as the next expiry → RAW remains 1.
- ETB control: pulse etb_trig_en_on[2] → channel 2 loads LOAD and counts. Assert etb_trig_en_off[2] together with an APB write of EN=1 → EN=0, VALUE frozen.
- Boundaries: LOAD=0 periodic → trig_out high every cycle. CNT_W=8 with pwdata=0x1FF → LOAD reads 0xFF. Read of 0x90 when NUM_CH=4 → prdata=0.
- Reset: presetn=0 for one edge mid-count with RAW=1 → all registers, intr and trig_out read 0 on the next cycle; counting resumes only after EN is re-written.

Source files
------------

// File: rtl/timer_nch_apb.sv
// N-channel down-counting timer bank on APB.
// Each channel has a LOAD/VALUE/CTRL/STAT block at c*0x10. Global interrupt
// and raw status views sit at 0xA0/0xA4. A channel expires in a cycle where
// it is enabled and VALUE is zero. Expiry sets RAW and pulses trig_out, then
// either reloads (periodic) or stops (one-shot).
module timer_nch_apb #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    input  logic [NUM_CH-1:0] etb_trig_en_on,
    input  logic [NUM_CH-1:0] etb_trig_en_off,
    output logic [NUM_CH-1:0] trig_out,
    output logic [NUM_CH-1:0] intr
);

    localparam int IDX_W = ADDR_W - 4;
    localparam logic [1:0] OFF_LOAD  = 2'd0;
    localparam logic [1:0] OFF_VALUE = 2'd1;
    localparam logic [1:0] OFF_CTRL  = 2'd2;
    localparam logic [1:0] OFF_STAT  = 2'd3;
    localparam logic [ADDR_W-1:0] INTSTAT_ADDR = ADDR_W'(8'hA0);
    localparam logic [ADDR_W-1:0] RAWSTAT_ADDR = ADDR_W'(8'hA4);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);

    // Per-channel state
    logic [CNT_W-1:0]  load_r  [NUM_CH];
    logic [CNT_W-1:0]  value_r [NUM_CH];
    logic [NUM_CH-1:0] en_r;
    logic [NUM_CH-1:0] mode_r;
    logic [NUM_CH-1:0] mask_r;
    logic [NUM_CH-1:0] raw_r;
    logic [NUM_CH-1:0] trig_r;

    // Next-state values
    logic [CNT_W-1:0]  load_nxt_s  [NUM_CH];
    logic [CNT_W-1:0]  value_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] en_nxt_s;
    logic [NUM_CH-1:0] mode_nxt_s;
    logic [NUM_CH-1:0] mask_nxt_s;
    logic [NUM_CH-1:0] raw_nxt_s;

    // Bus decode
    logic              wr_s;
    logic [IDX_W-1:0]  idx_s;
    logic [1:0]        off_s;
    logic              ch_hit_s;
    logic [NUM_CH-1:0] wr_ch_s;
    logic [NUM_CH-1:0] expire_s;
    logic [NUM_CH-1:0] intr_s;

    // Read-path channel selection
    logic [CNT_W-1:0]  ch_load_s;
    logic [CNT_W-1:0]  ch_value_s;
    logic [2:0]        ch_ctrl_s;
    logic              ch_raw_s;
    logic [31:0]       rd_data_s;

    // Address bits [1:0] and the write-data bits above CNT_W carry no meaning
    logic              unused_bus_s;

    assign wr_s         = psel & penable & pwrite;
    assign idx_s        = paddr[ADDR_W-1:4];
    assign off_s        = paddr[3:2];
    assign ch_hit_s     = (int'(idx_s) < NUM_CH);
    assign intr_s       = raw_r & ~mask_r;
    assign unused_bus_s = ^{paddr[1:0], pwdata};

    // Flag which channel (if any) a committed APB write targets
    always_comb begin
        wr_ch_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ch_s[c] = wr_s & (int'(idx_s) == c);
        end
    end

    // A channel expires in any cycle where it runs with a zero count
    always_comb begin
        expire_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            expire_s[c] = en_r[c] & (value_r[c] == '0);
        end
    end

    // Enable: one-shot expiry beats ETB off, which beats ETB on, which beats APB
    always_comb begin
        en_nxt_s = en_r;
        for (int c = 0; c < NUM_CH; c++) begin
            if (expire_s[c] && !mode_r[c]) begin
                en_nxt_s[c] = 1'b0;
            end else if (etb_trig_en_off[c]) begin
                en_nxt_s[c] = 1'b0;
            end else if (etb_trig_en_on[c]) begin
                en_nxt_s[c] = 1'b1;
            end else if (wr_ch_s[c] && (off_s == OFF_CTRL)) begin
                en_nxt_s[c] = pwdata[0];
            end else begin
                en_nxt_s[c] = en_r[c];
            end
        end
    end

    // Counter: load on rising enable, count down while running, reload on periodic expiry
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            value_nxt_s[c] = value_r[c];
            if (!en_r[c] && en_nxt_s[c]) begin
                value_nxt_s[c] = load_r[c];
            end else if (en_r[c] && (value_r[c] != '0)) begin
                value_nxt_s[c] = value_r[c] - CNT_ONE;
            end else if (expire_s[c] && mode_r[c]) begin
                value_nxt_s[c] = load_r[c];
            end else begin
                value_nxt_s[c] = value_r[c];
            end
        end
    end

    // Software-visible configuration and W1C status; an expiry outranks a clear
    always_comb begin
        mode_nxt_s = mode_r;
        mask_nxt_s = mask_r;
        raw_nxt_s  = raw_r;
        for (int c = 0; c < NUM_CH; c++) begin
            load_nxt_s[c] = load_r[c];
            if (wr_ch_s[c] && (off_s == OFF_LOAD)) begin
                load_nxt_s[c] = pwdata[CNT_W-1:0];
            end else begin
                load_nxt_s[c] = load_r[c];
            end
            if (wr_ch_s[c] && (off_s == OFF_CTRL)) begin
                mode_nxt_s[c] = pwdata[1];
                mask_nxt_s[c] = pwdata[2];
            end else begin
                mode_nxt_s[c] = mode_r[c];
                mask_nxt_s[c] = mask_r[c];
            end
            if (expire_s[c]) begin
                raw_nxt_s[c] = 1'b1;
            end else if (wr_ch_s[c] && (off_s == OFF_STAT) && pwdata[0]) begin
                raw_nxt_s[c] = 1'b0;
            end else begin
                raw_nxt_s[c] = raw_r[c];
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            en_r   <= '0;
            mode_r <= '0;
            mask_r <= '0;
            raw_r  <= '0;
            trig_r <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                load_r[c]  <= '0;
                value_r[c] <= '0;
            end
        end else begin
            en_r   <= en_nxt_s;
            mode_r <= mode_nxt_s;
            mask_r <= mask_nxt_s;
            raw_r  <= raw_nxt_s;
            trig_r <= expire_s;
            for (int c = 0; c < NUM_CH; c++) begin
                load_r[c]  <= load_nxt_s[c];
                value_r[c] <= value_nxt_s[c];
            end
        end
    end

    // Pick out the addressed channel's registers for the read path
    always_comb begin
        ch_load_s  = '0;
        ch_value_s = '0;
        ch_ctrl_s  = 3'b000;
        ch_raw_s   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_load_s  = ch_load_s  | ((int'(idx_s) == c) ? load_r[c]  : '0);
            ch_value_s = ch_value_s | ((int'(idx_s) == c) ? value_r[c] : '0);
            ch_ctrl_s  = ch_ctrl_s  | ((int'(idx_s) == c) ? {mask_r[c], mode_r[c], en_r[c]} : 3'b000);
            ch_raw_s   = ch_raw_s   | ((int'(idx_s) == c) & raw_r[c]);
        end
    end

    // Combinational read data; zero whenever no read is being addressed
    always_comb begin
        rd_data_s = 32'd0;
        if (psel && !pwrite) begin
            if (ch_hit_s) begin
                case (off_s)
                    OFF_LOAD:  rd_data_s = 32'(ch_load_s);
                    OFF_VALUE: rd_data_s = 32'(ch_value_s);
                    OFF_CTRL:  rd_data_s = {29'd0, ch_ctrl_s};
                    OFF_STAT:  rd_data_s = {31'd0, ch_raw_s};
                    default:   rd_data_s = 32'd0;
                endcase
            end else if (paddr[ADDR_W-1:2] == INTSTAT_ADDR[ADDR_W-1:2]) begin
                rd_data_s = 32'(intr_s);
            end else if (paddr[ADDR_W-1:2] == RAWSTAT_ADDR[ADDR_W-1:2]) begin
                rd_data_s = 32'(raw_r);
            end else begin
                rd_data_s = 32'd0;
            end
        end else begin
            rd_data_s = 32'd0;
        end
    end

    assign prdata   = rd_data_s;
    assign trig_out = trig_r;
    assign intr     = intr_s;

endmodule

// File: tb/tb_timer_nch_apb.sv
// Bench for timer_nch_apb: directed scenarios with literal expectations,
// then randomized APB and ETB traffic, all cross-checked every cycle against
// a behavioural model of the timer bank.
module tb_timer_nch_apb;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic           pclk = 1'b0;
    logic           presetn;
    logic           psel, penable, pwrite;
    logic [7:0]     paddr;
    logic [31:0]    pwdata;
    logic [31:0]    prdata;
    logic [NCH-1:0] etb_trig_en_on, etb_trig_en_off;
    logic [NCH-1:0] trig_out, intr;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    bit rnd_run  = 1'b0;

    timer_nch_apb #(.NUM_CH(NCH), .CNT_W(CW), .ADDR_W(8)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .etb_trig_en_on(etb_trig_en_on), .etb_trig_en_off(etb_trig_en_off),
        .trig_out(trig_out), .intr(intr)
    );

    always #5 pclk = ~pclk;

    // ---------------- behavioural model ----------------
    int m_load  [NCH];
    int m_value [NCH];
    bit m_en [NCH], m_mode [NCH], m_mask [NCH], m_raw [NCH], m_trig [NCH];

    function automatic bit wr_hit(int c, int off);
        return psel && penable && pwrite && (int'(paddr[7:4]) == c) && (int'(paddr[3:2]) == off);
    endfunction

    function automatic bit f_exp(int c);
        return m_en[c] && (m_value[c] == 0);
    endfunction

    function automatic bit f_en(int c);
        if (f_exp(c) && !m_mode[c]) return 1'b0;
        if (etb_trig_en_off[c])     return 1'b0;
        if (etb_trig_en_on[c])      return 1'b1;
        if (wr_hit(c, 2))           return pwdata[0];
        return m_en[c];
    endfunction

    function automatic int f_val(int c);
        if (!m_en[c]) return f_en(c) ? m_load[c] : m_value[c];
        if (m_value[c] > 0) return m_value[c] - 1;
        return m_mode[c] ? m_load[c] : 0;
    endfunction

    function automatic bit f_raw(int c);
        if (f_exp(c)) return 1'b1;
        if (wr_hit(c, 3) && pwdata[0]) return 1'b0;
        return m_raw[c];
    endfunction

    function automatic logic [31:0] m_read(logic [7:0] a);
        int ch = int'(a[7:4]);
        int off = int'(a[3:2]);
        logic [31:0] v = 32'd0;
        if (ch < NCH) begin
            case (off)
                0:       v = 32'(m_load[ch]);
                1:       v = 32'(m_value[ch]);
                2:       v = {29'd0, m_mask[ch], m_mode[ch], m_en[ch]};
                default: v = {31'd0, m_raw[ch]};
            endcase
        end else if (a[7:2] == 6'h28) begin
            for (int c = 0; c < NCH; c++) v[c] = m_raw[c] & ~m_mask[c];
        end else if (a[7:2] == 6'h29) begin
            for (int c = 0; c < NCH; c++) v[c] = m_raw[c];
        end
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_trig();
        logic [NCH-1:0] r = '0;
        for (int c = 0; c < NCH; c++) r[c] = m_trig[c];
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_intr();
        logic [NCH-1:0] r = '0;
        for (int c = 0; c < NCH; c++) r[c] = m_raw[c] & ~m_mask[c];
        return r;
    endfunction

    // Model advance on every clock edge
    always @(posedge pclk) begin
        for (int c = 0; c < NCH; c++) begin
            if (!presetn) begin
                m_load[c] <= 0; m_value[c] <= 0; m_en[c] <= 1'b0; m_mode[c] <= 1'b0;
                m_mask[c] <= 1'b0; m_raw[c] <= 1'b0; m_trig[c] <= 1'b0;
            end else begin
                m_load[c]  <= wr_hit(c, 0) ? int'(pwdata[CW-1:0]) : m_load[c];
                m_value[c] <= f_val(c);
                m_en[c]    <= f_en(c);
                m_mode[c]  <= wr_hit(c, 2) ? pwdata[1] : m_mode[c];
                m_mask[c]  <= wr_hit(c, 2) ? pwdata[2] : m_mask[c];
                m_raw[c]   <= f_raw(c);
                m_trig[c]  <= f_exp(c);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge pclk) begin
        if (chk_en) begin
            chk("cyc_trig_out", 32'(trig_out), 32'(exp_trig()));
            chk("cyc_intr", 32'(intr), 32'(exp_intr()));
            chk("cyc_prdata", prdata, (psel && !pwrite) ? m_read(paddr) : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1; penable = 1'b1; #1; d = prdata;
        @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    endtask

    task automatic count_trig(input logic [NCH-1:0] m, input int n, output int cnt);
        cnt = 0;
        for (int j = 0; j < n; j++) begin
            @(posedge pclk); #1;
            if ((trig_out & m) != '0) cnt++;
        end
    endtask

    logic [31:0] rd, v1, v2;
    int cnt, k;
    bit found;
    logic [7:0] ra;
    logic [31:0] rdat;
    int rch, roff;

    initial begin
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 32'd0; etb_trig_en_on = '0; etb_trig_en_off = '0;
        repeat (3) @(posedge pclk);
        #1; presetn = 1'b1; chk_en = 1'b1;

        // Reset state
        chk("rst_trig", 32'(trig_out), 32'd0);
        chk("rst_intr", 32'(intr), 32'd0);
        apb_read(8'h08, rd); chk("rst_ctrl0", rd, 32'd0);
        apb_read(8'hA4, rd); chk("rst_rawstat", rd, 32'd0);

        // Boundaries: LOAD truncated to CNT_W, absent channel and hole read 0
        apb_write(8'h00, 32'h1FF); apb_read(8'h00, rd); chk("load_trunc", rd, 32'hFF);
        apb_write(8'h90, 32'hFFFFFFFF); apb_read(8'h90, rd); chk("absent_ch", rd, 32'd0);
        apb_read(8'hA8, rd); chk("hole_read", rd, 32'd0);

        // Periodic, LOAD=3: one pulse per 4 cycles
        apb_write(8'h00, 32'd3); apb_write(8'h08, 32'h3);
        repeat (6) @(posedge pclk); #1;
        count_trig(4'b0001, 40, cnt); chk("periodic_pulses", 32'(cnt), 32'd10);
        chk("periodic_intr", 32'(intr[0]), 32'd1);
        apb_read(8'hA0, rd); chk("periodic_intstat", rd & 32'h1, 32'h1);
        apb_write(8'h08, 32'h0); apb_write(8'h0C, 32'h1);
        chk("w1c_intr", 32'(intr[0]), 32'd0);
        apb_read(8'hA4, rd); chk("w1c_raw", rd & 32'h1, 32'h0);

        // One-shot, LOAD=5: single pulse 6 cycles after the enable edge
        apb_write(8'h10, 32'd5); apb_write(8'h18, 32'h1);
        k = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge pclk); #1;
            if (trig_out[1]) begin k = j; break; end
        end
        chk("oneshot_latency", 32'(k), 32'd6);
        apb_read(8'h18, rd); chk("oneshot_ctrl", rd, 32'h0);
        apb_read(8'h14, rd); chk("oneshot_value", rd, 32'h0);
        count_trig(4'b0010, 20, cnt); chk("oneshot_no_repeat", 32'(cnt), 32'd0);

        // Masked channel and W1C colliding with expiry
        apb_write(8'h30, 32'd3); apb_write(8'h38, 32'h7);
        found = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(posedge pclk); #1;
            if (trig_out[3]) begin found = 1'b1; break; end
        end
        chk("mask_trig_seen", 32'(found), 32'd1);
        apb_write(8'h3C, 32'h1);   // clears RAW two cycles before next expiry
        apb_write(8'h3C, 32'h1);   // commits on the same edge as the next expiry
        apb_read(8'hA4, rd); chk("collision_raw", rd & 32'h8, 32'h8);
        apb_read(8'hA0, rd); chk("mask_intstat", rd & 32'h8, 32'h0);
        chk("mask_intr", 32'(intr[3]), 32'd0);
        apb_write(8'h38, 32'h0);

        // ETB enable pulse, then ETB off beating a concurrent APB enable
        apb_write(8'h20, 32'd10); apb_write(8'h28, 32'h2);
        etb_trig_en_on[2] = 1'b1; @(posedge pclk); #1; etb_trig_en_on[2] = 1'b0;
        apb_read(8'h24, rd); chk("etb_on_value", rd, 32'd9);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h28; pwdata = 32'h3;
        @(posedge pclk); #1; penable = 1'b1; etb_trig_en_off[2] = 1'b1;
        @(posedge pclk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; etb_trig_en_off[2] = 1'b0;
        apb_read(8'h28, rd); chk("etb_off_ctrl", rd, 32'h2);
        apb_read(8'h24, v1);
        repeat (3) @(posedge pclk); #1;
        apb_read(8'h24, v2); chk("etb_off_frozen", v2, v1);

        // LOAD=0 periodic: trig_out high every cycle
        apb_write(8'h00, 32'd0); apb_write(8'h08, 32'h3);
        repeat (2) @(posedge pclk); #1;
        count_trig(4'b0001, 10, cnt); chk("load0_continuous", 32'(cnt), 32'd10);
        chk("load0_intr", 32'(intr[0]), 32'd1);

        // Reset mid-count with RAW set
        presetn = 1'b0; @(posedge pclk); #1; presetn = 1'b1;
        chk("midrst_trig", 32'(trig_out), 32'd0);
        chk("midrst_intr", 32'(intr), 32'd0);
        apb_read(8'h08, rd); chk("midrst_ctrl0", rd, 32'd0);
        apb_read(8'h24, rd); chk("midrst_value2", rd, 32'd0);
        apb_read(8'hA4, rd); chk("midrst_rawstat", rd, 32'd0);
        count_trig(4'b1111, 10, cnt); chk("midrst_idle", 32'(cnt), 32'd0);

        // Randomized traffic with concurrent ETB pulses
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    rch = int'($urandom_range(0, 5));
                    roff = int'($urandom_range(0, 3));
                    if (rch == 5) ra = 8'hA0 + 8'(4 * $urandom_range(0, 2));
                    else ra = 8'(rch * 16 + roff * 4);
                    if (roff == 0) rdat = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
                    else if (roff == 2) rdat = 32'($urandom_range(0, 7));
                    else rdat = $urandom;
                    if ($urandom_range(0, 1) == 1) apb_write(ra, rdat);
                    else apb_read(ra, rd);
                    if ($urandom_range(0, 3) == 0) begin @(posedge pclk); #1; end
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    @(posedge pclk); #1;
                    for (int c = 0; c < NCH; c++) begin
                        etb_trig_en_on[c]  = ($urandom_range(0, 7) == 0);
                        etb_trig_en_off[c] = ($urandom_range(0, 9) == 0);
                    end
                end
                etb_trig_en_on = '0; etb_trig_en_off = '0;
            end
        join
        repeat (20) @(posedge pclk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
